seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the datapath's combinational 4-op ALU.
- Keeps the existing 2-bit opcode encodings (ADD/SUB/AND/ASR) as the low half of a 3-bit opcode, and adds OR, XOR, LSL and an iterative MUL.
- Adds NZCV flags and a start/done handshake, so the control unit can stall on variable-latency operations.

Parameters:
- WIDTH, 32: operand/result width; power of 2, >= 4.
- SHAMT_W, $clog2(WIDTH): width of the shift amount taken from b.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when busy=0.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; shifts use b[SHAMT_W-1:0] as the shift amount.
- alu_funct  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 ASR, 100 OR, 101 XOR, 110 LSL, 111 MUL.
- busy  out  1  iterative operation in progress.
- done  out  1  single-cycle pulse; result and flags valid from this cycle onward.
- result  out  WIDTH  registered result; holds until the next completion.
- flags  out  4  {N,Z,C,V}; registered, updated together with result.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, result=0, flags=0, internal counters and operand registers cleared. A reset mid-operation aborts with no done pulse. Leaving reset is synchronous to clk.
- States:
  - IDLE: accepts start.
  - RUN: iterative op in progress; busy=1.
- Accept: at edge E0, state=IDLE and start=1. a, b and alu_funct are latched; the inputs may change afterwards.
- Single-cycle ops:
  - Applies to ADD, SUB, AND, OR, XOR, and ASR/LSL with shamt=0.
  - result and flags are written at E0; done=1 for the cycle after E0; busy stays 0.
- Shifts with shamt=k>0:
  - At E0: go to RUN, busy=1, count=k.
  - Each edge shifts the working register one bit and decrements count. ASR fills with the sign bit; LSL fills with 0.
  - At E_k: result written, done=1 for one cycle, busy=0, return to IDLE.
  - Latency is k edges.
- MUL:
  - Shift-add over WIDTH iterations, one multiplier bit per edge.
  - done after E_WIDTH.
  - result = low WIDTH bits of the unsigned a*b. The low bits are identical for signed operands.
- Back-to-back: done is asserted while in IDLE, so start in the done cycle is accepted. There are no dead cycles.
- start while busy=1: ignored, not queued; the in-flight op is unaffected.
- done is never asserted two cycles in a row for one operation.
- Arithmetic: ADD = a+b and SUB = a+~b+1, both modulo 2^WIDTH.
- Flags:
  - Z: result==0.
  - N: result[WIDTH-1].
  - C for ADD: carry out.
  - C for SUB: carry out of a+~b+1, i.e. 1 = no borrow (a>=b unsigned).
  - C for ASR/LSL: last bit shifted out; 0 if shamt=0.
  - C for others: 0.
  - V for ADD/SUB: signed overflow (operand signs equal and result sign differs, after b inversion for SUB).
  - V for others: 0.
- Outputs change only on completion edges (or reset); stable otherwise.
- Target: 120-400 lines of RTL, single always_ff plus next-state logic. No combinational path from inputs to outputs.

Test Plan:
- Reset and basics: reset, then start ADD a=0x7FFFFFFF, b=1 -> next cycle done=1, result=0x80000000, flags N=1, Z=0, C=0, V=1; busy never 1.
- SUB: a=5, b=5 -> result=0, Z=1, C=1, V=0. Then a=0, b=1 -> result=0xFFFFFFFF, N=1, C=0.
- ASR: a=0x80000010, b=4 -> busy=1 for 4 cycles, done on the 4th edge, result=0xF8000001, C=0. With b=0 -> done next cycle, result=a, C=0.
- MUL: a=0x0001_0003, b=0x0000_0005 -> done exactly 32 edges after accept, result=0x0005_000F. start pulses while busy are ignored: exactly one done.
- Back-to-back: start held high with LSL a=1, b=31 followed by XOR -> LSL result=0x80000000, C=0, then XOR accepted in the LSL done cycle, done on the next cycle.
- Reset abort: rst_n low mid-MUL (iteration 10) -> busy, done, result and flags are 0 immediately (asynchronous), no done pulse. A fresh ADD after release works.

Source files
------------

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle ALU with NZCV flags, iterative shifts and shift-add multiply
module seq_alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alu_funct,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam int CNT_W = SHAMT_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_ASR = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_LSL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic             done_q, done_d;

    logic [SHAMT_W-1:0] shamt;
    logic               sub_op;
    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH:0]     sum_ext;
    logic [WIDTH-1:0]   step_work;
    logic               step_out;
    logic [WIDTH-1:0]   step_acc;
    logic               fin;
    logic [WIDTH-1:0]   fin_res;
    logic               fin_c;
    logic               fin_v;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        work_d   = work_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        result_d = result_q;
        flags_d  = flags_q;
        done_d   = 1'b0;
        fin      = 1'b0;
        fin_res  = '0;
        fin_c    = 1'b0;
        fin_v    = 1'b0;

        shamt   = b[SHAMT_W-1:0];
        sub_op  = (alu_funct == OP_SUB);
        b_eff   = sub_op ? ~b : b;
        sum_ext = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_op};

        // One bit per edge; C tracks whichever bit falls off the end
        if (op_q == OP_ASR) begin
            step_work = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            step_out  = work_q[0];
        end else begin
            step_work = {work_q[WIDTH-2:0], 1'b0};
            step_out  = work_q[WIDTH-1];
        end
        step_acc = work_q + (mplier_q[0] ? mcand_q : '0);

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d = alu_funct;
                    case (alu_funct)
                        OP_ADD, OP_SUB: begin
                            fin     = 1'b1;
                            fin_res = sum_ext[WIDTH-1:0];
                            fin_c   = sum_ext[WIDTH];
                            fin_v   = (a[WIDTH-1] == b_eff[WIDTH-1]) &&
                                      (sum_ext[WIDTH-1] != a[WIDTH-1]);
                        end
                        OP_AND: begin
                            fin     = 1'b1;
                            fin_res = a & b;
                        end
                        OP_OR: begin
                            fin     = 1'b1;
                            fin_res = a | b;
                        end
                        OP_XOR: begin
                            fin     = 1'b1;
                            fin_res = a ^ b;
                        end
                        OP_ASR, OP_LSL: begin
                            if (shamt == '0) begin
                                fin     = 1'b1;
                                fin_res = a;
                            end else begin
                                work_d  = a;
                                count_d = CNT_W'(shamt);
                                state_d = RUN;
                            end
                        end
                        default: begin
                            work_d   = '0;
                            mcand_d  = a;
                            mplier_d = b;
                            count_d  = CNT_W'(WIDTH);
                            state_d  = RUN;
                        end
                    endcase
                end
            end
            default: begin
                count_d = count_q - CNT_ONE;
                if (op_q == OP_MUL) begin
                    work_d   = step_acc;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    fin_res  = step_acc;
                end else begin
                    work_d  = step_work;
                    fin_res = step_work;
                    fin_c   = step_out;
                end
                fin = (count_q == CNT_ONE);
            end
        endcase

        if (fin) begin
            result_d = fin_res;
            flags_d  = {fin_res[WIDTH-1], ~|fin_res, fin_c, fin_v};
            done_d   = 1'b1;
            state_d  = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            work_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            result_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            work_q   <= work_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = done_q;
    assign result = result_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - directed self-checking bench for seq_alu
`timescale 1ns/1ps
module tb_seq_alu;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  alu_funct;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [3:0]  flags;

    int n_checks;
    int n_fail;
    int lat;
    bit busy_hi;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_ASR = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_LSL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    seq_alu #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .alu_funct (alu_funct),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one op at a negedge and returns in the done cycle; lat counts edges after accept
    task automatic run_op(input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv,
                          input int poke_at, output int lat_o, output bit busy_o);
        alu_funct = f;
        a         = av;
        b         = bv;
        start     = 1'b1;
        lat_o     = -1;
        busy_o    = 1'b0;
        do begin
            @(negedge clk);
            lat_o++;
            a      = ~av;
            b      = ~bv;
            busy_o = busy_o | busy;
            if (lat_o == poke_at) begin
                start     = 1'b1;
                alu_funct = OP_ADD;
            end else begin
                start = 1'b0;
            end
        end while (!done && lat_o < 100);
        start = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        alu_funct = OP_ADD;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", {28'd0, flags}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(OP_ADD, 32'h7FFF_FFFF, 32'h1, -1, lat, busy_hi);
        chk("add_ovf_lat", lat, 32'd0);
        chk("add_ovf_busy", {31'd0, busy_hi}, 32'd0);
        chk("add_ovf_result", result, 32'h8000_0000);
        chk("add_ovf_flags", {28'd0, flags}, 32'b1001);
        @(negedge clk);
        chk("add_done_pulse", {31'd0, done}, 32'd0);
        chk("add_result_hold", result, 32'h8000_0000);

        run_op(OP_SUB, 32'd5, 32'd5, -1, lat, busy_hi);
        chk("sub_eq_result", result, 32'd0);
        chk("sub_eq_flags", {28'd0, flags}, 32'b0110);
        run_op(OP_SUB, 32'd0, 32'd1, -1, lat, busy_hi);
        chk("sub_borrow_result", result, 32'hFFFF_FFFF);
        chk("sub_borrow_flags", {28'd0, flags}, 32'b1000);

        run_op(OP_ADD, 32'hFFFF_FFFF, 32'd1, -1, lat, busy_hi);
        chk("add_carry_result", result, 32'd0);
        chk("add_carry_flags", {28'd0, flags}, 32'b0110);

        run_op(OP_AND, 32'hFF00_FF00, 32'h0F0F_0F0F, -1, lat, busy_hi);
        chk("and_result", result, 32'h0F00_0F00);
        chk("and_flags", {28'd0, flags}, 32'b0000);

        run_op(OP_ASR, 32'h8000_0010, 32'd4, -1, lat, busy_hi);
        chk("asr4_lat", lat, 32'd4);
        chk("asr4_busy", {31'd0, busy_hi}, 32'd1);
        chk("asr4_result", result, 32'hF800_0001);
        chk("asr4_flags", {28'd0, flags}, 32'b1000);
        chk("asr4_busy_done", {31'd0, busy}, 32'd0);

        run_op(OP_ASR, 32'h8000_0010, 32'd0, -1, lat, busy_hi);
        chk("asr0_lat", lat, 32'd0);
        chk("asr0_result", result, 32'h8000_0010);
        chk("asr0_flags", {28'd0, flags}, 32'b1000);

        run_op(OP_ASR, 32'h0000_0006, 32'd2, -1, lat, busy_hi);
        chk("asr_c_result", result, 32'h0000_0001);
        chk("asr_c_flags", {28'd0, flags}, 32'b0010);

        run_op(OP_MUL, 32'h0001_0003, 32'h0000_0005, 5, lat, busy_hi);
        chk("mul_lat", lat, 32'd32);
        chk("mul_result", result, 32'h0005_000F);
        chk("mul_flags", {28'd0, flags}, 32'b0000);
        @(negedge clk);
        chk("mul_single_done", {31'd0, done}, 32'd0);

        run_op(OP_LSL, 32'd1, 32'd31, -1, lat, busy_hi);
        chk("lsl31_lat", lat, 32'd31);
        chk("lsl31_result", result, 32'h8000_0000);
        chk("lsl31_flags", {28'd0, flags}, 32'b1000);
        run_op(OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, -1, lat, busy_hi);
        chk("b2b_xor_lat", lat, 32'd0);
        chk("b2b_xor_result", result, 32'h0FF0_0FF0);
        chk("b2b_xor_flags", {28'd0, flags}, 32'b0000);

        run_op(OP_SUB, 32'd0, 32'd1, -1, lat, busy_hi);
        alu_funct = OP_MUL;
        a         = 32'd3;
        b         = 32'd7;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort_pre_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_flags", {28'd0, flags}, 32'd0);
        @(negedge clk);
        chk("abort_no_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(OP_ADD, 32'd2, 32'd3, -1, lat, busy_hi);
        chk("post_abort_lat", lat, 32'd0);
        chk("post_abort_result", result, 32'd5);
        chk("post_abort_flags", {28'd0, flags}, 32'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
